// File: rtl/sw_affine_array.sv
// Linear systolic array of PE_NUM affine-gap Smith-Waterman cells.
// Cell k holds query base k. Reference bases stream in at cell 0 and shift one cell
// per accepted step. Each cell keeps its own best score and column. A final scan
// picks the best cell.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_q_valid/i_q_base        query load stream (LOAD only), o_q_ready
//   i_r_valid/i_r_base/i_r_last  reference stream (RUN only), o_r_ready
//   o_valid                   one-cycle result strobe
//   o_max_score/row/col       best local score and its end coordinates (held)
module sw_affine_array #(
  parameter int PE_NUM = 16,
  parameter int WIDTH  = 19,
  parameter int COL_W  = 16,
  parameter int G_OPEN = 430,
  parameter int G_EXT  = 30
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_q_valid,
  input  logic [1:0]                i_q_base,
  output logic                      o_q_ready,
  input  logic                      i_r_valid,
  input  logic [1:0]                i_r_base,
  input  logic                      i_r_last,
  output logic                      o_r_ready,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_max_score,
  output logic [$clog2(PE_NUM)-1:0] o_max_row,
  output logic [COL_W-1:0]          o_max_col
);

  localparam int RW     = $clog2(PE_NUM);
  localparam int XW     = WIDTH + 2;  // headroom so sums cannot wrap before saturation
  localparam int NegInf = -(2 ** (WIDTH - 2));
  localparam int PosMax = 2 ** (WIDTH - 1) - 1;

  localparam logic signed [WIDTH-1:0] NEG_INF = WIDTH'(NegInf);
  localparam logic signed [XW-1:0]    X_NEG   = XW'(NegInf);
  localparam logic signed [XW-1:0]    X_MAX   = XW'(PosMax);
  localparam logic signed [XW-1:0]    X_OPEN  = XW'(G_OPEN);
  localparam logic signed [XW-1:0]    X_EXT   = XW'(G_EXT);

  typedef enum logic [2:0] {StLoad, StRun, StDrain, StReduce, StDone} state_e;

  function automatic logic signed [XW-1:0] ext(input logic signed [WIDTH-1:0] x);
    return XW'(x);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] x);
    if (x > X_MAX) return WIDTH'(X_MAX);
    if (x < X_NEG) return NEG_INF;
    return x[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] max2(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Gap recurrence shared by I (from own previous column) and D (from upper cell).
  function automatic logic signed [WIDTH-1:0] gap(input logic signed [WIDTH-1:0] v,
                                                  input logic signed [WIDTH-1:0] g);
    return max2(sat(ext(v) - X_OPEN), sat(ext(g) - X_EXT));
  endfunction

  function automatic logic signed [XW-1:0] sub_score(input logic [1:0] q, input logic [1:0] r);
    int s;
    if (q == r) begin
      s = (q == 2'd0) ? 91 : 100;
    end else if ({q, r} inside {4'b0010, 4'b1000, 4'b0111, 4'b1101}) begin
      s = -25;   // A/G, C/T
    end else if ({q, r} inside {4'b0001, 4'b0100, 4'b1011, 4'b1110}) begin
      s = -90;   // A/C, G/T
    end else begin
      s = -100;
    end
    return XW'(s);
  endfunction

  // Control state
  state_e            state_q, state_d;
  logic [RW-1:0]     q_cnt_q, drain_cnt_q, red_idx_q;
  logic [COL_W-1:0]  col_cnt_q;
  logic signed [WIDTH-1:0] best_score_q;
  logic [RW-1:0]     best_row_q;
  logic [COL_W-1:0]  best_col_q;
  logic              valid_q;
  logic [WIDTH-1:0]  max_score_q;
  logic [RW-1:0]     max_row_q;
  logic [COL_W-1:0]  max_col_q;

  // Cell state
  logic [1:0]              q_q    [PE_NUM];
  logic signed [WIDTH-1:0] v_q    [PE_NUM];
  logic signed [WIDTH-1:0] i_q    [PE_NUM];
  logic signed [WIDTH-1:0] d_q    [PE_NUM];
  logic signed [WIDTH-1:0] diag_q [PE_NUM];
  logic signed [WIDTH-1:0] mx_q   [PE_NUM];
  logic [COL_W-1:0]        mxc_q  [PE_NUM];
  // Base pipeline between cells; the last cell has nothing downstream.
  logic [1:0]              rb_q   [PE_NUM-1];
  logic                    rv_q   [PE_NUM-1];
  logic [COL_W-1:0]        rc_q   [PE_NUM-1];

  // Cell inputs and next values
  logic [1:0]              b_in   [PE_NUM];
  logic                    bv_in  [PE_NUM];
  logic [COL_W-1:0]        c_in   [PE_NUM];
  logic signed [WIDTH-1:0] top_v  [PE_NUM];
  logic signed [WIDTH-1:0] top_d  [PE_NUM];
  logic signed [WIDTH-1:0] v_n    [PE_NUM];
  logic signed [WIDTH-1:0] i_n    [PE_NUM];
  logic signed [WIDTH-1:0] d_n    [PE_NUM];

  logic q_acc, r_acc, clear, step;

  assign q_acc = (state_q == StLoad) && i_q_valid;
  assign r_acc = (state_q == StRun) && i_r_valid;
  assign clear = q_acc && (q_cnt_q == RW'(PE_NUM - 1));
  // A stall in RUN freezes the whole array; DRAIN steps unconditionally.
  assign step  = r_acc || (state_q == StDrain);

  assign o_q_ready   = (state_q == StLoad);
  assign o_r_ready   = (state_q == StRun);
  assign o_valid     = valid_q;
  assign o_max_score = max_score_q;
  assign o_max_row   = max_row_q;
  assign o_max_col   = max_col_q;

  for (genvar k = 0; k < PE_NUM; k++) begin : g_cell
    if (k == 0) begin : g_head
      assign b_in[k]  = i_r_base;
      assign bv_in[k] = (state_q == StRun);
      assign c_in[k]  = col_cnt_q;
      assign top_v[k] = '0;
      assign top_d[k] = NEG_INF;
    end else begin : g_body
      assign b_in[k]  = rb_q[k-1];
      assign bv_in[k] = rv_q[k-1];
      assign c_in[k]  = rc_q[k-1];
      assign top_v[k] = v_q[k-1];
      assign top_d[k] = d_q[k-1];
    end
    assign i_n[k] = gap(v_q[k], i_q[k]);
    assign d_n[k] = gap(top_v[k], top_d[k]);
    assign v_n[k] = max2(max2('0, sat(ext(diag_q[k]) + sub_score(q_q[k], b_in[k]))),
                         max2(i_n[k], d_n[k]));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:   if (clear) state_d = StRun;
      StRun:    if (r_acc && i_r_last) state_d = StDrain;
      StDrain:  if (drain_cnt_q == RW'(PE_NUM - 2)) state_d = StReduce;
      StReduce: if (red_idx_q == RW'(PE_NUM - 1)) state_d = StDone;
      StDone:   state_d = StLoad;
      default:  state_d = StLoad;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StLoad;
      q_cnt_q      <= '0;
      drain_cnt_q  <= '0;
      red_idx_q    <= '0;
      col_cnt_q    <= '0;
      best_score_q <= '0;
      best_row_q   <= '0;
      best_col_q   <= '0;
      valid_q      <= 1'b0;
      max_score_q  <= '0;
      max_row_q    <= '0;
      max_col_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      if (q_acc) q_cnt_q <= clear ? '0 : q_cnt_q + 1'b1;
      if (clear) begin
        col_cnt_q <= '0;
      end else if (r_acc) begin
        col_cnt_q <= col_cnt_q + 1'b1;
      end
      drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
      red_idx_q   <= (state_q == StReduce) ? red_idx_q + 1'b1 : '0;
      // Strictly-greater replacement keeps the lowest row on ties.
      if (clear) begin
        best_score_q <= '0;
        best_row_q   <= '0;
        best_col_q   <= '0;
      end else if ((state_q == StReduce) && (mx_q[red_idx_q] > best_score_q)) begin
        best_score_q <= mx_q[red_idx_q];
        best_row_q   <= red_idx_q;
        best_col_q   <= mxc_q[red_idx_q];
      end
      if (state_q == StDone) begin
        valid_q     <= 1'b1;
        max_score_q <= best_score_q;
        max_row_q   <= best_row_q;
        max_col_q   <= best_col_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < PE_NUM; k++) q_q[k] <= '0;
    end else if (q_acc) begin
      q_q[q_cnt_q] <= i_q_base;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < PE_NUM; k++) begin
        v_q[k]    <= '0;
        i_q[k]    <= NEG_INF;
        d_q[k]    <= NEG_INF;
        diag_q[k] <= '0;
        mx_q[k]   <= '0;
        mxc_q[k]  <= '0;
      end
      for (int k = 0; k < PE_NUM - 1; k++) begin
        rb_q[k] <= '0;
        rv_q[k] <= 1'b0;
        rc_q[k] <= '0;
      end
    end else if (clear) begin
      // Cleared values double as first-column / first-row boundary conditions.
      for (int k = 0; k < PE_NUM; k++) begin
        v_q[k]    <= '0;
        i_q[k]    <= NEG_INF;
        d_q[k]    <= NEG_INF;
        diag_q[k] <= '0;
        mx_q[k]   <= '0;
        mxc_q[k]  <= '0;
      end
      for (int k = 0; k < PE_NUM - 1; k++) begin
        rb_q[k] <= '0;
        rv_q[k] <= 1'b0;
        rc_q[k] <= '0;
      end
    end else if (step) begin
      for (int k = 0; k < PE_NUM - 1; k++) begin
        rb_q[k] <= b_in[k];
        rv_q[k] <= bv_in[k];
        rc_q[k] <= c_in[k];
      end
      for (int k = 0; k < PE_NUM; k++) begin
        if (bv_in[k]) begin
          v_q[k]    <= v_n[k];
          i_q[k]    <= i_n[k];
          d_q[k]    <= d_n[k];
          // Upper cell's V for this column becomes the diagonal for the next one.
          diag_q[k] <= top_v[k];
          if (v_n[k] > mx_q[k]) begin
            mx_q[k]  <= v_n[k];
            mxc_q[k] <= c_in[k];
          end
        end
      end
    end
  end

endmodule
